// File: rtl/uart_defines.sv
// Shared UART constants and helpers: divisor width, MCR bit positions, line levels.
package uart_defines;

    localparam int   UART_DL_W      = 16;
    localparam int   UART_MC_LB     = 4;
    localparam logic UART_LINE_IDLE = 1'b1;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser for an asynchronous input; flops reset to RST_VAL.
// Latency N clk cycles; no backpressure.
module uart_sync #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff_q;
    logic [N-1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[N-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= {N{RST_VAL}};
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[N-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: divisor latch, 16x-baud enable strobe, input sync, loopback mux, majority filter.
// srx_filt lags the pad by SYNC_STAGES+2 clk (filter bypassed); no backpressure.
module uart_rx_frontend
    import uart_defines::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          FILTER_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 wb_rst_i,
    input  logic                 srx_pad_i,
    input  logic                 stx_loop_i,
    input  logic                 loopback,
    input  logic                 dl_wr_lsb,
    input  logic                 dl_wr_msb,
    input  logic [7:0]           dl_data,
    output logic [UART_DL_W-1:0] dl,
    output logic                 enable,
    output logic                 srx_filt,
    output logic                 rx_fall
);

    logic [UART_DL_W-1:0] dl_q, dl_d;
    logic [UART_DL_W-1:0] dlc_q, dlc_d;
    logic                 start_dlc_q, start_dlc_d;
    logic                 enable_q, enable_d;
    logic                 s_sync;
    logic                 s_src_q, s_src_d;
    logic [2:0]           hist_q, hist_d;
    logic                 srx_filt_q, srx_filt_d;
    logic                 rx_fall_q, rx_fall_d;

    uart_sync #(
        .N       (SYNC_STAGES),
        .RST_VAL (UART_LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (wb_rst_i),
        .d   (srx_pad_i),
        .q   (s_sync)
    );

    // Any divisor write restarts the count from the new value, so a stale period never fires.
    always_comb begin
        dl_d = dl_q;
        if (dl_wr_lsb) dl_d[7:0]  = dl_data;
        if (dl_wr_msb) dl_d[15:8] = dl_data;
        start_dlc_d = dl_wr_lsb | dl_wr_msb;

        dlc_d = '0;
        if (dl_q != '0) begin
            if (start_dlc_q || dlc_q == '0) dlc_d = dl_q - 16'd1;
            else                            dlc_d = dlc_q - 16'd1;
        end
        enable_d = (dl_q != '0) && (dlc_q == '0) && !start_dlc_q;
    end

    always_comb begin
        s_src_d = loopback ? stx_loop_i : s_sync;
        hist_d  = hist_q;
        if (FILTER_EN) begin
            if (enable_q) hist_d = {hist_q[1:0], s_src_q};
            srx_filt_d = majority3(hist_q);
        end else begin
            srx_filt_d = s_src_q;
        end
        rx_fall_d = srx_filt_q & ~srx_filt_d;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dl_q        <= '0;
            dlc_q       <= '0;
            start_dlc_q <= 1'b0;
            enable_q    <= 1'b0;
            s_src_q     <= UART_LINE_IDLE;
            hist_q      <= {3{UART_LINE_IDLE}};
            srx_filt_q  <= UART_LINE_IDLE;
            rx_fall_q   <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            dlc_q       <= dlc_d;
            start_dlc_q <= start_dlc_d;
            enable_q    <= enable_d;
            s_src_q     <= s_src_d;
            hist_q      <= hist_d;
            srx_filt_q  <= srx_filt_d;
            rx_fall_q   <= rx_fall_d;
        end
    end

    assign dl       = dl_q;
    assign enable   = enable_q;
    assign srx_filt = srx_filt_q;
    assign rx_fall  = rx_fall_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed scenarios plus randomized traffic against a timing-rule model.
module tb_uart_rx_frontend;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        srx_pad_i = 1'b1;
    logic        stx_loop_i = 1'b1;
    logic        loopback = 1'b0;
    logic        dl_wr_lsb = 1'b0;
    logic        dl_wr_msb = 1'b0;
    logic [7:0]  dl_data = 8'h00;
    logic [15:0] dl;
    logic        enable;
    logic        srx_filt;
    logic        rx_fall;

    int tests = 0;
    int fails = 0;

    uart_rx_frontend #(.SYNC_STAGES(2), .FILTER_EN(1'b1)) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .srx_pad_i  (srx_pad_i),
        .stx_loop_i (stx_loop_i),
        .loopback   (loopback),
        .dl_wr_lsb  (dl_wr_lsb),
        .dl_wr_msb  (dl_wr_msb),
        .dl_data    (dl_data),
        .dl         (dl),
        .enable     (enable),
        .srx_filt   (srx_filt),
        .rx_fall    (rx_fall)
    );

    always #5 clk = ~clk;

    // Reference model: enable timing from the write instant and divisor; the line
    // is the pad delayed through the sync chain, sampled on ticks, 2-of-3 voted.
    int        n = 0;
    int        m_w = 0;
    bit [15:0] m_dl;
    bit        m_en, m_filt, m_fall, m_ssrc;
    bit [2:0]  m_hist;
    bit        pad_hist[$];

    task automatic model_reset();
        m_dl = 16'h0; m_en = 1'b0; m_filt = 1'b1; m_fall = 1'b0;
        m_ssrc = 1'b1; m_hist = 3'b111;
        pad_hist = '{1'b1, 1'b1};
    endtask

    task automatic tick();
        bit lb, stx, pad, rst, wl, wm, src, newf;
        bit [7:0] d;
        int k, dv;
        lb = loopback; stx = stx_loop_i; pad = srx_pad_i; rst = wb_rst_i;
        wl = dl_wr_lsb; wm = dl_wr_msb; d = dl_data;
        @(posedge clk);
        #1;
        n++;
        if (rst) begin
            model_reset();
        end else begin
            src  = lb ? stx : pad_hist[0];
            newf = ($countones(m_hist) >= 2);
            if (m_en) m_hist = {m_hist[1:0], m_ssrc};
            m_ssrc = src;
            m_fall = m_filt & ~newf;
            m_filt = newf;
            k  = n - m_w;
            dv = int'(m_dl);
            m_en = (dv != 0) && (k >= dv + 1) && (((k - dv - 1) % dv) == 0);
            if (wl) m_dl[7:0]  = d;
            if (wm) m_dl[15:8] = d;
            if (wl || wm) m_w = n;
            pad_hist.push_back(pad);
            void'(pad_hist.pop_front());
        end
    endtask

    task automatic wr(input bit l, input bit m, input bit [7:0] d);
        dl_wr_lsb = l; dl_wr_msb = m; dl_data = d;
        tick();
        dl_wr_lsb = 1'b0; dl_wr_msb = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        wb_rst_i = 1'b1;
        repeat (3) tick();
        tests++;
        if (dl !== 16'h0 || enable !== 1'b0 || srx_filt !== 1'b1 || rx_fall !== 1'b0) begin
            fails++;
            $display("FAIL reset: dl=%h en=%b filt=%b fall=%b, want 0000 0 1 0", dl, enable, srx_filt, rx_fall);
        end
        wb_rst_i = 1'b0;
    endtask

    task automatic test_dl_zero();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) srx_pad_i = ~srx_pad_i;
            tick();
            tests++;
            if (enable !== 1'b0 || srx_filt !== 1'b1 || rx_fall !== 1'b0) begin
                fails++;
                $display("FAIL dl_zero cyc %0d: en=%b filt=%b fall=%b, want 0 1 0", i, enable, srx_filt, rx_fall);
            end
        end
        srx_pad_i = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_period();
        int pulses = 0;
        bit exp;
        wr(1'b1, 1'b0, 8'h04);
        wr(1'b0, 1'b1, 8'h00);
        for (int k = 1; k <= 405; k++) begin
            tick();
            exp = (k >= 5) && (((k - 5) % 4) == 0);
            if (enable === 1'b1) pulses++;
            tests++;
            if (enable !== exp) begin
                fails++;
                $display("FAIL period k=%0d: enable=%b want %b", k, enable, exp);
            end
        end
        tests++;
        if (pulses != 101) begin
            fails++;
            $display("FAIL period_count: got %0d pulses want 101", pulses);
        end
    endtask

    task automatic test_rewrite();
        bit exp;
        wr(1'b1, 1'b0, 8'd10);
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (enable !== 1'b0) begin
                fails++;
                $display("FAIL rewrite_pre k=%0d: enable=%b want 0", k, enable);
            end
        end
        wr(1'b1, 1'b0, 8'd3);
        tests++;
        if (enable !== 1'b0 || dl !== 16'd3) begin
            fails++;
            $display("FAIL rewrite_wr: enable=%b dl=%0d want 0 3", enable, dl);
        end
        for (int k = 1; k <= 25; k++) begin
            tick();
            exp = (k >= 4) && (((k - 4) % 3) == 0);
            tests++;
            if (enable !== exp) begin
                fails++;
                $display("FAIL rewrite k=%0d: enable=%b want %b", k, enable, exp);
            end
        end
    endtask

    task automatic test_glitch();
        int falls = 0;
        int lows = 0;
        bit prev;
        wr(1'b1, 1'b0, 8'd2);
        repeat (10) tick();
        srx_pad_i = 1'b0;
        repeat (2) tick();
        srx_pad_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (srx_filt !== 1'b1 || rx_fall !== 1'b0) begin
                fails++;
                $display("FAIL glitch cyc %0d: filt=%b fall=%b want 1 0", i, srx_filt, rx_fall);
            end
        end
        srx_pad_i = 1'b0;
        prev = srx_filt;
        for (int i = 0; i < 40; i++) begin
            if (i == 6) srx_pad_i = 1'b1;
            tick();
            if (rx_fall === 1'b1) falls++;
            if (prev === 1'b1 && srx_filt === 1'b0) lows++;
            prev = srx_filt;
            tests++;
            if (srx_filt !== m_filt || rx_fall !== m_fall) begin
                fails++;
                $display("FAIL edge cyc %0d: filt=%b fall=%b want %b %b", i, srx_filt, rx_fall, m_filt, m_fall);
            end
        end
        tests++;
        if (falls != 1 || lows != 1) begin
            fails++;
            $display("FAIL edge_count: rx_fall pulses %0d, filt falls %0d, want 1 1", falls, lows);
        end
    endtask

    task automatic test_loopback();
        bit [9:0] frame = 10'b1_0101_0101_0;
        int falls = 0;
        stx_loop_i = 1'b1;
        loopback = 1'b1;
        tick();
        srx_pad_i = 1'b0;
        wr(1'b1, 1'b0, 8'd1);
        repeat (32) tick();
        for (int b = 0; b < 11; b++) begin
            stx_loop_i = (b < 10) ? frame[b] : 1'b1;
            for (int t = 0; t < 16; t++) begin
                tick();
                if (rx_fall === 1'b1) falls++;
                tests++;
                if (srx_filt !== m_filt || rx_fall !== m_fall) begin
                    fails++;
                    $display("FAIL loopback bit %0d t %0d: filt=%b fall=%b want %b %b", b, t, srx_filt, rx_fall, m_filt, m_fall);
                end
            end
        end
        tests++;
        if (falls != 5 || srx_filt !== 1'b1) begin
            fails++;
            $display("FAIL loopback_frame: falls %0d filt %b, want 5 1", falls, srx_filt);
        end
        srx_pad_i = 1'b1;
        repeat (4) tick();
        loopback = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                dl_wr_lsb = 1'b1; dl_data = 8'($urandom_range(1, 12));
            end else if ($urandom_range(0, 199) == 0) begin
                dl_wr_msb = 1'b1; dl_data = 8'h00;
            end
            if ($urandom_range(0, 5) == 0) srx_pad_i = ~srx_pad_i;
            if ($urandom_range(0, 4) == 0) stx_loop_i = ~stx_loop_i;
            if ($urandom_range(0, 199) == 0) loopback = ~loopback;
            tick();
            dl_wr_lsb = 1'b0; dl_wr_msb = 1'b0;
            tests++;
            if (enable !== m_en || srx_filt !== m_filt || rx_fall !== m_fall || dl !== m_dl) begin
                fails++;
                $display("FAIL random cyc %0d: en=%b filt=%b fall=%b dl=%h want %b %b %b %h",
                         i, enable, srx_filt, rx_fall, dl, m_en, m_filt, m_fall, m_dl);
            end
        end
        loopback = 1'b0; srx_pad_i = 1'b1; stx_loop_i = 1'b1;
        repeat (40) tick();
    endtask

    task automatic test_async_reset();
        wr(1'b1, 1'b1, 8'd2);
        wr(1'b0, 1'b1, 8'd0);
        srx_pad_i = 1'b0;
        repeat (20) tick();
        wr(1'b1, 1'b0, 8'h34);
        wr(1'b0, 1'b1, 8'h12);
        repeat (3) tick();
        tests++;
        if (dl !== 16'h1234 || srx_filt !== 1'b0) begin
            fails++;
            $display("FAIL arst_pre: dl=%h filt=%b want 1234 0", dl, srx_filt);
        end
        #3;
        wb_rst_i = 1'b1;
        #1;
        model_reset();
        tests++;
        if (dl !== 16'h0 || enable !== 1'b0 || srx_filt !== 1'b1 || rx_fall !== 1'b0) begin
            fails++;
            $display("FAIL arst_now: dl=%h en=%b filt=%b fall=%b want 0000 0 1 0", dl, enable, srx_filt, rx_fall);
        end
        srx_pad_i = 1'b1;
        repeat (2) tick();
        wb_rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (rx_fall !== 1'b0 || srx_filt !== 1'b1 || enable !== 1'b0) begin
                fails++;
                $display("FAIL arst_post cyc %0d: fall=%b filt=%b en=%b want 0 1 0", i, rx_fall, srx_filt, enable);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dl_zero();
        test_period();
        test_rewrite();
        test_glitch();
        test_loopback();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
